muldiv_sequencer: RTL and testbench

//   Multicycle sequencer for the HI/LO arithmetic resource of the multicycle MIPS core.
//   - Accepts one MULT or DIV request from the main control FSM.
//   - Iterates a radix-2 signed multiply (Booth) or a signed restoring divide, one bit per cycle.
//   - Produces HI/LO results, a HI/LO write strobe and a divide-by-zero flag.
//   - The control FSM stalls in its MULT/DIV wait state while busy=1 and resumes on done.

---
 rtl/muldiv_sequencer_if.sv | 26 ++
 rtl/muldiv_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the main control FSM (master) and the
// HI/LO multiply/divide sequencer (slave).
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div0;
  logic             hilo_we;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div0, hilo_we, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div0, hilo_we, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// One-bit-per-cycle signed Booth multiplier and signed restoring divider
// that produces HI/LO results for the multicycle MIPS core.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input logic               clock,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [WIDTH-1:0] operand;
  logic             booth_prev;
  logic             a_neg;
  logic             b_neg;
  logic             div0_flag;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic             busy_c;
  logic             done_c;
  logic             div0_c;
  logic             hilo_we_c;

  logic             last_step;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   mult_hi_next;
  logic [WIDTH-1:0] mult_lo_next;

  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH:0]   div_hi_next;
  logic [WIDTH-1:0] div_lo_next;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  assign last_step = (cnt == CW'(WIDTH - 1));
  assign b_zero    = (bus.b == '0);
  // The most negative value maps onto itself, which reads correctly as unsigned 2^(W-1).
  assign a_mag     = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_mag     = bus.b[WIDTH-1] ? -bus.b : bus.b;

  assign bus.busy    = busy_c;
  assign bus.done    = done_c;
  assign bus.div0    = div0_c;
  assign bus.hilo_we = hilo_we_c;
  assign bus.hi      = hi_reg;
  assign bus.lo      = lo_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy_c     = 1'b1;
    done_c     = 1'b0;
    div0_c     = 1'b0;
    hilo_we_c  = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) begin
          if (!bus.op) begin
            state_next = MULT;
          end else if (b_zero) begin
            state_next = DONE;
          end else begin
            state_next = DIV;
          end
        end
      end
      MULT, DIV: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_c     = 1'b1;
        div0_c     = div0_flag;
        hilo_we_c  = ~div0_flag;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Booth step: the accumulator carries one guard bit so that subtracting
  // the most negative multiplicand cannot overflow.
  always_comb begin
    m_ext = {operand[WIDTH-1], operand};
    case ({work_lo[0], booth_prev})
      2'b01:   booth_sum = work_hi + m_ext;
      2'b10:   booth_sum = work_hi - m_ext;
      default: booth_sum = work_hi;
    endcase
    mult_hi_next = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mult_lo_next = {booth_sum[0], work_lo[WIDTH-1:1]};
  end

  always_comb begin
    div_shift = {work_hi[WIDTH-1:0], work_lo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, operand};
    if (div_diff[WIDTH+1]) begin
      div_hi_next = div_shift;
    end else begin
      div_hi_next = div_diff[WIDTH:0];
    end
    div_lo_next = {work_lo[WIDTH-2:0], ~div_diff[WIDTH+1]};
    quot_fix    = (a_neg ^ b_neg) ? -div_lo_next : div_lo_next;
    rem_fix     = a_neg ? -div_hi_next[WIDTH-1:0] : div_hi_next[WIDTH-1:0];
  end

  // Working registers iterate freely; hi/lo only take the final step's value.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      work_hi    <= '0;
      work_lo    <= '0;
      operand    <= '0;
      booth_prev <= 1'b0;
      a_neg      <= 1'b0;
      b_neg      <= 1'b0;
      div0_flag  <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt        <= '0;
            work_hi    <= '0;
            booth_prev <= 1'b0;
            div0_flag  <= bus.op & b_zero;
            if (!bus.op) begin
              work_lo <= bus.b;
              operand <= bus.a;
            end else begin
              work_lo <= a_mag;
              operand <= b_mag;
              a_neg   <= bus.a[WIDTH-1];
              b_neg   <= bus.b[WIDTH-1];
            end
          end
        end
        MULT: begin
          work_hi    <= mult_hi_next;
          work_lo    <= mult_lo_next;
          booth_prev <= work_lo[0];
          cnt        <= cnt + CW'(1);
          if (last_step) begin
            hi_reg <= mult_hi_next[WIDTH-1:0];
            lo_reg <= mult_lo_next;
          end
        end
        DIV: begin
          work_hi <= div_hi_next;
          work_lo <= div_lo_next;
          cnt     <= cnt + CW'(1);
          if (last_step) begin
            hi_reg <= rem_fix;
            lo_reg <= quot_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboarded bench for muldiv_sequencer: table of MULT/DIV vectors, random
// vectors checked against native 64-bit arithmetic, and multi-cycle corner cases.
module tb_muldiv_sequencer;

  localparam int WIDTH = 32;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   vec_count = 0;
  int   miscompares = 0;
  int   next_id = 0;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] held_hi = '0;
  logic [31:0] held_lo = '0;
  vec_t        vecs[13];

  muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

  muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic void model(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                                output logic [31:0] hi_o, output logic [31:0] lo_o);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'(signed'(a_i));
    sb = longint'(signed'(b_i));
    if (!op_i) begin
      p    = sa * sb;
      hi_o = p[63:32];
      lo_o = p[31:0];
    end else begin
      p    = sa / sb;
      lo_o = p[31:0];
      p    = sa % sb;
      hi_o = p[31:0];
    end
  endfunction

  // Results are compared as the DUT reports them; between reports hi/lo must hold.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          vec_count++;
          miscompares++;
          $display("[TB] FAIL unexpected_done: got done=1, expected done=0 at cycle %0d", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check_output($sformatf("op%0d_hi", mon_e.id), bus.hi, mon_e.hi);
          check_output($sformatf("op%0d_lo", mon_e.id), bus.lo, mon_e.lo);
          check_output($sformatf("op%0d_div0", mon_e.id), {31'd0, bus.div0}, {31'd0, mon_e.div0});
          check_output($sformatf("op%0d_hilo_we", mon_e.id), {31'd0, bus.hilo_we}, {31'd0, ~mon_e.div0});
          check_output($sformatf("op%0d_done_cycle", mon_e.id), cyc, mon_e.cyc);
          if (!mon_e.div0) begin
            held_hi = mon_e.hi;
            held_lo = mon_e.lo;
          end
        end
      end else if (bus.hi !== held_hi || bus.lo !== held_lo || bus.div0 !== 1'b0 || bus.hilo_we !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL hold: got hi=0x%08h lo=0x%08h div0=%b we=%b, expected hi=0x%08h lo=0x%08h div0=0 we=0",
                 bus.hi, bus.lo, bus.div0, bus.hilo_we, held_hi, held_lo);
      end
    end
  end

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < WIDTH + 20; i++) begin
      @(posedge clock);
      #1;
      if (exp_q.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vec_count++;
      miscompares++;
      $display("[TB] FAIL timeout_%s: got busy=%b pending=%0d, expected idle", name, bus.busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic push_expect(input logic [31:0] hi_e, input logic [31:0] lo_e, input logic div0_e);
    exp_t e;
    e.id   = next_id;
    e.hi   = hi_e;
    e.lo   = lo_e;
    e.div0 = div0_e;
    e.cyc  = cyc + 1 + (div0_e ? 0 : WIDTH);
    next_id++;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                                input logic [31:0] hi_e, input logic [31:0] lo_e, input logic div0_e);
    @(posedge clock);
    #1;
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    push_expect(hi_e, lo_e, div0_e);
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.op    = 1'($urandom_range(0, 1));
    bus.a     = $urandom;
    bus.b     = $urandom;
    wait_idle($sformatf("op%0d", next_id - 1));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rhi;
    logic [31:0] rlo;
    logic        rop;
    bit          seen;

    vecs[0]  = '{op: 1'b0, a: 32'd7,          b: 32'hFFFF_FFFD, hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB, div0: 1'b0};
    vecs[1]  = '{op: 1'b0, a: 32'h8000_0000, b: 32'h8000_0000, hi: 32'h4000_0000, lo: 32'h0000_0000, div0: 1'b0};
    vecs[2]  = '{op: 1'b1, a: 32'hFFFF_FFF9, b: 32'd2,          hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, div0: 1'b0};
    vecs[3]  = '{op: 1'b1, a: 32'h8000_0000, b: 32'hFFFF_FFFF, hi: 32'h0000_0000, lo: 32'h8000_0000, div0: 1'b0};
    vecs[4]  = '{op: 1'b1, a: 32'h0000_0451, b: 32'h0000_0020, hi: 32'h0000_0011, lo: 32'h0000_0022, div0: 1'b0};
    vecs[5]  = '{op: 1'b1, a: 32'd5,          b: 32'd0,          hi: 32'h0000_0011, lo: 32'h0000_0022, div0: 1'b1};
    vecs[6]  = '{op: 1'b1, a: 32'd100,        b: 32'hFFFF_FFF9, hi: 32'h0000_0002, lo: 32'hFFFF_FFF2, div0: 1'b0};
    vecs[7]  = '{op: 1'b1, a: 32'hFFFF_FF9C, b: 32'hFFFF_FFF9, hi: 32'hFFFF_FFFE, lo: 32'h0000_000E, div0: 1'b0};
    vecs[8]  = '{op: 1'b0, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, hi: 32'h0000_0000, lo: 32'h0000_0001, div0: 1'b0};
    vecs[9]  = '{op: 1'b0, a: 32'h7FFF_FFFF, b: 32'h7FFF_FFFF, hi: 32'h3FFF_FFFF, lo: 32'h0000_0001, div0: 1'b0};
    vecs[10] = '{op: 1'b1, a: 32'd7,          b: 32'd9,          hi: 32'h0000_0007, lo: 32'h0000_0000, div0: 1'b0};
    vecs[11] = '{op: 1'b1, a: 32'h8000_0000, b: 32'd1,          hi: 32'h0000_0000, lo: 32'h8000_0000, div0: 1'b0};
    vecs[12] = '{op: 1'b0, a: 32'd0,          b: 32'h1234_5678, hi: 32'h0000_0000, lo: 32'h0000_0000, div0: 1'b0};

    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check_output("reset_busy",    {31'd0, bus.busy},    32'd0);
    check_output("reset_done",    {31'd0, bus.done},    32'd0);
    check_output("reset_div0",    {31'd0, bus.div0},    32'd0);
    check_output("reset_hilo_we", {31'd0, bus.hilo_we}, 32'd0);
    check_output("reset_hi",      bus.hi,               32'd0);
    check_output("reset_lo",      bus.lo,               32'd0);

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].div0);
    end

    for (int i = 0; i < 8; i++) begin
      rop = 1'(i % 2);
      ra  = $urandom;
      rb  = $urandom;
      if (rop && rb == 32'd0) rb = 32'd1;
      model(rop, ra, rb, rhi, rlo);
      apply_stimulus(rop, ra, rb, rhi, rlo, 1'b0);
    end

    // A start while busy, and another in the DONE cycle, must both be dropped.
    @(posedge clock);
    #1;
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'd3;
    bus.b     = 32'd4;
    push_expect(32'd0, 32'd12, 1'b0);
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 32'd100;
    bus.b     = 32'd0;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < WIDTH + 10; i++) begin
      @(negedge clock);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check_output("busy_start_done_seen", {31'd0, seen}, 32'd1);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'd5;
    bus.b     = 32'd5;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    wait_idle("ignored_start");
    repeat (WIDTH + 8) @(posedge clock);
    #1;
    check_output("done_cycle_start_ignored", {31'd0, bus.busy}, 32'd0);

    // Reset part-way through a divide abandons it without a done pulse.
    @(posedge clock);
    #1;
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 32'd1000;
    bus.b     = 32'd3;
    push_expect(32'd1, 32'd333, 1'b0);
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    held_hi = '0;
    held_lo = '0;
    check_output("midop_reset_busy", {31'd0, bus.busy}, 32'd0);
    check_output("midop_reset_hi",   bus.hi,            32'd0);
    check_output("midop_reset_lo",   bus.lo,            32'd0);
    repeat (WIDTH + 8) @(posedge clock);
    apply_stimulus(1'b0, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0);

    repeat (4) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
